wm8731_spi_ctrl: RTL

- Sequences an instance of piso_shift_reg to write one 16-bit control word to the WM8731 codec over its 3-wire (SPI-mode) control port.
- Accepts a register write request: {addr_i[6:0], data_i[8:0]}.
- Loads the word into the PISO, generates SCLK, shifts the word out MSB first, then pulses CSB high so the codec latches it.
- Sits between the codec-init sequencer/host logic and the codec pins.

---
 rtl/wm8731_ctrl_pkg.sv | 35 +++
 rtl/piso_shift_reg.sv | 32 +++
 rtl/wm8731_spi_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wm8731_ctrl_pkg.sv
// Shared widths, FSM state encoding and WM8731 register map for the codec control port.
package wm8731_ctrl_pkg;

    localparam int ADDR_WD = 7;
    localparam int DATA_WD = 9;
    localparam int WORD_WD = ADDR_WD + DATA_WD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_LATCH = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam logic [ADDR_WD-1:0] REG_LINVOL   = 7'h00;
    localparam logic [ADDR_WD-1:0] REG_RINVOL   = 7'h01;
    localparam logic [ADDR_WD-1:0] REG_LHPOUT   = 7'h02;
    localparam logic [ADDR_WD-1:0] REG_RHPOUT   = 7'h03;
    localparam logic [ADDR_WD-1:0] REG_ANALOG   = 7'h04;
    localparam logic [ADDR_WD-1:0] REG_DIGITAL  = 7'h05;
    localparam logic [ADDR_WD-1:0] REG_POWER    = 7'h06;
    localparam logic [ADDR_WD-1:0] REG_IFACE    = 7'h07;
    localparam logic [ADDR_WD-1:0] REG_SAMPLING = 7'h08;
    localparam logic [ADDR_WD-1:0] REG_ACTIVE   = 7'h09;
    localparam logic [ADDR_WD-1:0] REG_RESET    = 7'h0F;

    // The codec expects the address in the top bits, data in the bottom nine.
    function automatic logic [WORD_WD-1:0] make_word(input logic [ADDR_WD-1:0] addr,
                                                     input logic [DATA_WD-1:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB out first; bit 0 refills from pdata_i[0].
module piso_shift_reg #(
    parameter int WD = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          shift_en_i,
    input  logic [WD-1:0] pdata_i,
    output logic          sdata_o
);

    logic [WD-1:0] sr_q;

    // Load when en_i without shift_en_i, shift left when both are set, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (en_i) begin
            if (shift_en_i) begin
                sr_q <= {sr_q[WD-2:0], pdata_i[0]};
            end else begin
                sr_q <= pdata_i;
            end
        end else begin
            sr_q <= sr_q;
        end
    end

    assign sdata_o = sr_q[WD-1];

endmodule

// File: rtl/wm8731_spi_ctrl.sv
// Writes one 16-bit control word to the WM8731 3-wire port: load PISO, clock out MSB first, pulse CSB.
module wm8731_spi_ctrl
    import wm8731_ctrl_pkg::*;
#(
    parameter int WD      = WORD_WD,
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic [ADDR_WD-1:0] addr_i,
    input  logic [DATA_WD-1:0] data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               sclk_o,
    output logic               sdin_o,
    output logic               csb_o
);

    localparam int DW         = $clog2(CLK_DIV + 1);
    localparam int BW         = $clog2(WD);
    localparam int DIV_PRE_I  = (CLK_DIV > 1) ? (CLK_DIV - 2) : 0;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV_PRE_I);
    localparam logic [BW-1:0] BIT_LAST = BW'(WD - 1);

    state_e        state_q;
    logic [DW-1:0] div_q;
    logic [BW-1:0] bit_q;
    logic [WD-1:0] word_q;
    logic          busy_q;
    logic          done_q;
    logic          sclk_q;
    logic          csb_q;

    logic          div_last_s;
    logic          more_bits_s;
    logic          piso_en_s;
    logic          piso_shift_s;
    logic          piso_rst_n_s;

    assign div_last_s   = (div_q == DIV_LAST);
    assign more_bits_s  = (bit_q < BIT_LAST);
    // The shift happens on the edge that drops SCLK, so SDIN settles during the low phase.
    assign piso_en_s    = (state_q == ST_LOAD) || ((state_q == ST_HIGH) && div_last_s && more_bits_s);
    assign piso_shift_s = (state_q == ST_HIGH);
    assign piso_rst_n_s = ~rst_i;

    // Transfer sequencer with registered pin and handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            csb_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= 1'b0;
                    if (req_i) begin
                        word_q  <= WD'(make_word(addr_i, data_i));
                        busy_q  <= 1'b1;
                        csb_q   <= 1'b0;
                        state_q <= ST_LOAD;
                    end else begin
                        csb_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    div_q   <= '0;
                    bit_q   <= '0;
                    state_q <= ST_LOW;
                end
                ST_LOW: begin
                    if (div_last_s) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_HIGH: begin
                    if (div_last_s) begin
                        div_q  <= '0;
                        sclk_q <= 1'b0;
                        if (more_bits_s) begin
                            bit_q   <= bit_q + BW'(1);
                            state_q <= ST_LOW;
                        end else begin
                            state_q <= ST_LATCH;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_LATCH: begin
                    // CSB rising on exit is the latch edge; done lands on the final GAP cycle.
                    if (div_last_s) begin
                        div_q   <= '0;
                        csb_q   <= 1'b1;
                        done_q  <= (CLK_DIV == 1);
                        state_q <= ST_GAP;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                ST_GAP: begin
                    if (div_last_s) begin
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        div_q  <= div_q + DW'(1);
                        done_q <= (div_q == DIV_PRE);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    div_q   <= '0;
                    bit_q   <= '0;
                    busy_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    csb_q   <= 1'b1;
                end
            endcase
        end
    end

    piso_shift_reg #(
        .WD(WD)
    ) u_piso (
        .clk_i      (clk_i),
        .rst_ni     (piso_rst_n_s),
        .en_i       (piso_en_s),
        .shift_en_i (piso_shift_s),
        .pdata_i    (word_q),
        .sdata_o    (sdin_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sclk_o = sclk_q;
    assign csb_o  = csb_q;

endmodule
